// File: rtl/rd_ddr_seq_op.sv
// Multi-channel DDR read sequencer: walks NUM_CH address streams round-robin,
// one arbitrated read request at a time, throttled by the consumer's ready.
module rd_ddr_seq_op #(
   parameter int ADDR_WIDTH    = 30,
   parameter int DATA_NUM_BITS = 16,
   parameter int CNT_WIDTH     = 16,
   parameter int NUM_CH        = 2,
   parameter int CH_BITS       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                         clk_i,
   input  logic                         rstn_i,
   input  logic                         init_calib_complete_i,
   input  logic                         start_i,
   input  logic                         abort_i,
   input  logic [NUM_CH*ADDR_WIDTH-1:0] cfg_base_addr_i,
   input  logic [ADDR_WIDTH-1:0]        cfg_stride_i,
   input  logic [DATA_NUM_BITS-1:0]     cfg_burst_num_i,
   input  logic [CNT_WIDTH-1:0]         cfg_req_num_i,
   input  logic                         ip_ready_i,
   input  logic                         arbitor_ack_i,
   input  logic                         rd_ddr_done_i,
   output logic                         rd_req_o,
   output logic                         rd_ddr_en_o,
   output logic [DATA_NUM_BITS-1:0]     rd_burst_num_o,
   output logic [ADDR_WIDTH-1:0]        rd_start_addr_o,
   output logic [CH_BITS-1:0]           rd_ch_o,
   output logic                         busy_o,
   output logic                         done_o,
   output logic                         aborted_o,
   output logic [CNT_WIDTH-1:0]         req_cnt_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_REQ_WAIT, S_RD_PROC, S_DONE, S_ABORT
   } state_t;

   state_t                     r_state, w_state_next;
   logic [ADDR_WIDTH-1:0]      r_addr [NUM_CH];
   logic [ADDR_WIDTH-1:0]      r_stride;
   logic [DATA_NUM_BITS-1:0]   r_burst_cfg;
   logic [CNT_WIDTH-1:0]       r_req_num;
   logic [CNT_WIDTH-1:0]       r_req_cnt;
   logic [CH_BITS-1:0]         r_ch;
   logic [DATA_NUM_BITS-1:0]   r_rd_burst;
   logic [ADDR_WIDTH-1:0]      r_rd_addr;
   logic [CH_BITS-1:0]         r_rd_ch;
   logic                       r_busy, r_done, r_aborted;

   logic                       w_run, w_start, w_step, w_ch_last, w_finish, w_rd_req;
   logic [CNT_WIDTH-1:0]       w_cnt_inc;

   // Losing calibration freezes every register and silences both handshakes.
   assign w_run     = init_calib_complete_i;
   assign w_start   = (r_state == S_IDLE) & start_i;
   assign w_step    = (r_state == S_RD_PROC) & rd_ddr_done_i;
   assign w_ch_last = (r_ch == CH_BITS'(NUM_CH - 1));
   assign w_cnt_inc = r_req_cnt + CNT_WIDTH'(1);
   assign w_finish  = w_ch_last & (w_cnt_inc == r_req_num);
   assign w_rd_req  = (r_state == S_REQ_WAIT) & ip_ready_i & ~abort_i & w_run;

   assign rd_req_o        = w_rd_req;
   assign rd_ddr_en_o     = (r_state == S_RD_PROC) & ~rd_ddr_done_i & w_run;
   assign rd_burst_num_o  = r_rd_burst;
   assign rd_start_addr_o = r_rd_addr;
   assign rd_ch_o         = r_rd_ch;
   assign busy_o          = r_busy;
   assign done_o          = r_done;
   assign aborted_o       = r_aborted;
   assign req_cnt_o       = r_req_cnt;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i)    r_state <= S_IDLE;
      else if (w_run) r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:
            if (start_i) w_state_next = (cfg_req_num_i == '0) ? S_DONE : S_REQ_WAIT;
         S_REQ_WAIT:
            if (abort_i)                        w_state_next = S_ABORT;
            else if (w_rd_req && arbitor_ack_i) w_state_next = S_RD_PROC;
         // Abort is only honoured once the in-flight read has drained.
         S_RD_PROC:
            if (rd_ddr_done_i) begin
               if (abort_i)       w_state_next = S_ABORT;
               else if (w_finish) w_state_next = S_DONE;
               else               w_state_next = S_REQ_WAIT;
            end
         S_DONE:  w_state_next = S_IDLE;
         S_ABORT: w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
               r_addr[gi] <= '0;
            end else if (w_run) begin
               if (w_start)
                  r_addr[gi] <= cfg_base_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
               else if (w_step && (r_ch == CH_BITS'(gi)))
                  r_addr[gi] <= r_addr[gi] + r_stride;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_stride    <= '0;
         r_burst_cfg <= '0;
         r_req_num   <= '0;
         r_req_cnt   <= '0;
         r_ch        <= '0;
         r_rd_burst  <= '0;
         r_rd_addr   <= '0;
         r_rd_ch     <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_aborted   <= 1'b0;
      end else if (w_run) begin
         r_done    <= (r_state == S_DONE);
         r_aborted <= (r_state == S_ABORT);
         case (r_state)
            S_IDLE:
               if (start_i) begin
                  r_stride    <= cfg_stride_i;
                  r_burst_cfg <= cfg_burst_num_i;
                  r_req_num   <= cfg_req_num_i;
                  r_ch        <= '0;
                  r_req_cnt   <= '0;
                  r_busy      <= 1'b1;
               end
            S_REQ_WAIT: begin
               r_rd_addr  <= r_addr[r_ch];
               r_rd_ch    <= r_ch;
               r_rd_burst <= (w_rd_req && arbitor_ack_i) ? r_burst_cfg : '0;
            end
            S_RD_PROC:
               if (rd_ddr_done_i) begin
                  r_ch <= w_ch_last ? '0 : r_ch + CH_BITS'(1);
                  if (w_ch_last) r_req_cnt <= w_cnt_inc;
               end
            S_DONE:  r_busy <= 1'b0;
            S_ABORT: r_busy <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rd_ddr_seq_op.sv
// Directed bench for rd_ddr_seq_op (2 channels, 30-bit addresses).
module tb_rd_ddr_seq_op;

   logic        clk_i = 1'b0;
   logic        rstn_i = 1'b0;
   logic        init_calib_complete_i = 1'b1;
   logic        start_i = 1'b0, abort_i = 1'b0;
   logic [59:0] cfg_base_addr_i = '0;
   logic [29:0] cfg_stride_i = '0;
   logic [15:0] cfg_burst_num_i = '0;
   logic [15:0] cfg_req_num_i = '0;
   logic        ip_ready_i = 1'b1, arbitor_ack_i = 1'b1, rd_ddr_done_i = 1'b0;
   logic        rd_req_o, rd_ddr_en_o, busy_o, done_o, aborted_o;
   logic [15:0] rd_burst_num_o, req_cnt_o;
   logic [29:0] rd_start_addr_o;
   logic [0:0]  rd_ch_o;

   int n_checks = 0, n_errors = 0;
   int n_done = 0, n_abort = 0, n_req = 0;

   rd_ddr_seq_op #(.ADDR_WIDTH(30), .DATA_NUM_BITS(16), .CNT_WIDTH(16),
                   .NUM_CH(2), .CH_BITS(1)) dut (
      .clk_i(clk_i), .rstn_i(rstn_i), .init_calib_complete_i(init_calib_complete_i),
      .start_i(start_i), .abort_i(abort_i), .cfg_base_addr_i(cfg_base_addr_i),
      .cfg_stride_i(cfg_stride_i), .cfg_burst_num_i(cfg_burst_num_i),
      .cfg_req_num_i(cfg_req_num_i), .ip_ready_i(ip_ready_i),
      .arbitor_ack_i(arbitor_ack_i), .rd_ddr_done_i(rd_ddr_done_i),
      .rd_req_o(rd_req_o), .rd_ddr_en_o(rd_ddr_en_o), .rd_burst_num_o(rd_burst_num_o),
      .rd_start_addr_o(rd_start_addr_o), .rd_ch_o(rd_ch_o), .busy_o(busy_o),
      .done_o(done_o), .aborted_o(aborted_o), .req_cnt_o(req_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   always @(negedge clk_i) begin
      if (done_o)    n_done++;
      if (aborted_o) n_abort++;
      if (rd_req_o)  n_req++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic tick();
      @(negedge clk_i);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end else begin
         $display("ok   %s: %0h", tag, obs);
      end
   endtask

   task automatic start_job(input logic [29:0] b0, input logic [29:0] b1, input logic [29:0] st,
                            input logic [15:0] burst, input logic [15:0] num);
      cfg_base_addr_i = {b1, b0};
      cfg_stride_i    = st;
      cfg_burst_num_i = burst;
      cfg_req_num_i   = num;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      cfg_base_addr_i = '1;
      cfg_stride_i    = 30'h5;
      cfg_burst_num_i = 16'hBEEF;
      cfg_req_num_i   = 16'h7;
   endtask

   task automatic wait_en(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (rd_ddr_en_o) begin
            ok = 1'b1;
            return;
         end
         tick();
      end
   endtask

   task automatic serve(input string tag, input logic [29:0] a, input logic [0:0] ch,
                        input logic [15:0] b);
      bit ok;
      wait_en(ok);
      check({tag, "_en_seen"}, ok, 1);
      if (!ok) return;
      check({tag, "_addr"}, rd_start_addr_o, a);
      check({tag, "_ch"}, rd_ch_o, ch);
      check({tag, "_burst"}, rd_burst_num_o, b);
      rd_ddr_done_i = 1'b1;
      tick();
      rd_ddr_done_i = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      bit ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (done_o) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      check({tag, "_done_seen"}, ok, 1);
   endtask

   task automatic wait_abort(input string tag);
      bit ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (aborted_o) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      check({tag, "_abort_seen"}, ok, 1);
   endtask

   initial begin
      int s_done, s_abort, s_req;
      repeat (3) tick();
      rstn_i = 1'b1;
      tick();

      // Reset state
      check("rst_req", rd_req_o, 0);
      check("rst_en", rd_ddr_en_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      check("rst_abort", aborted_o, 0);
      check("rst_addr", rd_start_addr_o, 0);
      check("rst_burst", rd_burst_num_o, 0);
      check("rst_ch", rd_ch_o, 0);
      check("rst_cnt", req_cnt_o, 0);

      // Basic interleaved job, cfg scrambled after start
      s_done = n_done; s_req = n_req;
      start_job(30'h1000, 30'h8000, 30'h90, 16'd17, 16'd3);
      check("t1_first_req", rd_req_o, 1);
      serve("t1_r0", 30'h1000, 1'b0, 16'd17);
      serve("t1_r1", 30'h8000, 1'b1, 16'd17);
      serve("t1_r2", 30'h1090, 1'b0, 16'd17);
      serve("t1_r3", 30'h8090, 1'b1, 16'd17);
      serve("t1_r4", 30'h1120, 1'b0, 16'd17);
      serve("t1_r5", 30'h8120, 1'b1, 16'd17);
      wait_done("t1");
      check("t1_cnt", req_cnt_o, 3);
      check("t1_busy_off", busy_o, 0);
      tick();
      check("t1_done_1cyc", done_o, 0);
      repeat (3) tick();
      check("t1_done_pulses", n_done - s_done, 1);
      check("t1_req_cycles", n_req - s_req, 6);

      // Zero requests
      s_req = n_req;
      start_job(30'h0, 30'h0, 30'h10, 16'd1, 16'd0);
      check("t2_busy_c1", busy_o, 1);
      check("t2_done_c1", done_o, 0);
      tick();
      check("t2_done_c2", done_o, 1);
      check("t2_busy_c2", busy_o, 0);
      tick();
      check("t2_done_c3", done_o, 0);
      check("t2_no_req", n_req - s_req, 0);

      // Consumer not ready for 10 cycles
      ip_ready_i = 1'b0;
      start_job(30'h2000, 30'h4000, 30'h10, 16'd3, 16'd1);
      s_req = n_req;
      repeat (10) tick();
      check("t3_req_held", n_req - s_req, 0);
      check("t3_en_low", rd_ddr_en_o, 0);
      check("t3_busy", busy_o, 1);
      ip_ready_i = 1'b1;
      serve("t3_r0", 30'h2000, 1'b0, 16'd3);
      serve("t3_r1", 30'h4000, 1'b1, 16'd3);
      wait_done("t3");

      // Abort during request 2 is deferred until its done
      begin
         bit ok;
         s_done = n_done; s_abort = n_abort;
         start_job(30'h1000, 30'h8000, 30'h90, 16'd5, 16'd3);
         serve("t4_r0", 30'h1000, 1'b0, 16'd5);
         wait_en(ok);
         check("t4_r1_en_seen", ok, 1);
         check("t4_r1_addr", rd_start_addr_o, 30'h8000);
         abort_i = 1'b1;
         s_req = n_req;
         for (int i = 0; i < 3; i++) begin
            check("t4_en_held", rd_ddr_en_o, 1);
            tick();
         end
         rd_ddr_done_i = 1'b1;
         #1;
         check("t4_en_drop", rd_ddr_en_o, 0);
         tick();
         rd_ddr_done_i = 1'b0;
         wait_abort("t4");
         check("t4_busy_off", busy_o, 0);
         repeat (4) tick();
         abort_i = 1'b0;
         check("t4_abort_pulses", n_abort - s_abort, 1);
         check("t4_no_done", n_done - s_done, 0);
         check("t4_no_req", n_req - s_req, 0);
      end

      // Start and abort together: one abort pulse, no reads
      s_done = n_done; s_abort = n_abort; s_req = n_req;
      abort_i = 1'b1;
      start_job(30'h100, 30'h200, 30'h10, 16'd1, 16'd2);
      repeat (5) tick();
      abort_i = 1'b0;
      check("t5_abort_pulses", n_abort - s_abort, 1);
      check("t5_no_done", n_done - s_done, 0);
      check("t5_no_req", n_req - s_req, 0);

      // Calibration loss freezes REQ_WAIT
      ip_ready_i = 1'b0;
      start_job(30'h500, 30'h600, 30'h10, 16'd2, 16'd1);
      tick();
      init_calib_complete_i = 1'b0;
      ip_ready_i = 1'b1;
      s_req = n_req;
      repeat (5) tick();
      check("t6_req_forced", n_req - s_req, 0);
      check("t6_en_low", rd_ddr_en_o, 0);
      check("t6_busy", busy_o, 1);
      init_calib_complete_i = 1'b1;
      #1;
      check("t6_req_resume", rd_req_o, 1);
      serve("t6_r0", 30'h500, 1'b0, 16'd2);
      serve("t6_r1", 30'h600, 1'b1, 16'd2);
      wait_done("t6");

      // Address wrap at 2^30
      start_job(30'h3FFFFFF0, 30'h3FFFFFE0, 30'h20, 16'd1, 16'd2);
      serve("t7_r0", 30'h3FFFFFF0, 1'b0, 16'd1);
      serve("t7_r1", 30'h3FFFFFE0, 1'b1, 16'd1);
      serve("t7_r2", 30'h00000010, 1'b0, 16'd1);
      serve("t7_r3", 30'h00000000, 1'b1, 16'd1);
      wait_done("t7");
      check("t7_cnt", req_cnt_o, 2);

      // Asynchronous reset mid-job
      begin
         bit ok;
         start_job(30'h100, 30'h200, 30'h40, 16'd7, 16'd4);
         serve("t8_r0", 30'h100, 1'b0, 16'd7);
         serve("t8_r1", 30'h200, 1'b1, 16'd7);
         wait_en(ok);
         check("t8_r2_en_seen", ok, 1);
         check("t8_r2_addr", rd_start_addr_o, 30'h140);
         check("t8_cnt", req_cnt_o, 1);
         s_done = n_done; s_abort = n_abort;
         rstn_i = 1'b0;
         #1;
         check("t8_en", rd_ddr_en_o, 0);
         check("t8_busy", busy_o, 0);
         check("t8_addr", rd_start_addr_o, 0);
         check("t8_burst", rd_burst_num_o, 0);
         check("t8_rcnt", req_cnt_o, 0);
         tick();
         rstn_i = 1'b1;
         repeat (5) tick();
         check("t8_req", rd_req_o, 0);
         check("t8_no_done", n_done - s_done, 0);
         check("t8_no_abort", n_abort - s_abort, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/rd_ddr_seq_op.md
Name: rd_ddr_seq_op

Overview:
- Parametrised multi-channel DDR read sequencer that drives the read path of rd_wr_interface.
- Runtime-configured per job: per-channel base address, address stride, bursts per request and requests per channel.
- Issues requests round-robin across channels and arbitrates through a req/ack handshake.
- Throttled by the consumer's ready signal; reports progress, completion and abort.

Parameters:
ADDR_WIDTH, 30, DDR address width
DATA_NUM_BITS, 16, width of burst-count field (value = bursts-1)
CNT_WIDTH, 16, width of request counter
NUM_CH, 2, number of interleaved read channels (1..8)
CH_BITS, 1, clog2(NUM_CH), minimum 1

Ports:
clk_i  in  1  clock
rstn_i  in  1  reset; asynchronous assert, active-low
init_calib_complete_i  in  1  DDR calibrated; FSM frozen while low
start_i  in  1  job start pulse; honoured only in IDLE
abort_i  in  1  level; terminates the job at the next safe point
cfg_base_addr_i  in  NUM_CH*ADDR_WIDTH  channel c base at bits [c*ADDR_WIDTH +: ADDR_WIDTH]
cfg_stride_i  in  ADDR_WIDTH  address increment per request per channel
cfg_burst_num_i  in  DATA_NUM_BITS  bursts per request minus 1
cfg_req_num_i  in  CNT_WIDTH  requests per channel
ip_ready_i  in  1  consumer can accept the next request's data
arbitor_ack_i  in  1  arbiter grant
rd_ddr_done_i  in  1  current request fully read
rd_req_o  out  1  arbiter request
rd_ddr_en_o  out  1  read-path enable
rd_burst_num_o  out  DATA_NUM_BITS  bursts-1 for the active request
rd_start_addr_o  out  ADDR_WIDTH  start address of the active request
rd_ch_o  out  CH_BITS  channel of the active request
busy_o  out  1  job in progress
done_o  out  1  one-cycle pulse on normal completion
aborted_o  out  1  one-cycle pulse on abort completion
req_cnt_o  out  CNT_WIDTH  completed request rounds

Behaviour:
- Reset values:
  - state IDLE.
  - All outputs 0, including rd_start_addr_o, rd_burst_num_o, rd_ch_o and req_cnt_o.
  - Per-channel address registers 0.
- init_calib_complete_i low: no state change and all registers hold; rd_req_o and rd_ddr_en_o are forced to 0.
- IDLE:
  - On start_i, latch all cfg_* inputs.
  - Channel pointer := 0; req_cnt_o := 0; busy_o := 1.
  - If cfg_req_num_i == 0, go to DONE; otherwise go to REQ_WAIT.
- REQ_WAIT:
  - rd_req_o = ip_ready_i & ~abort_i (combinational).
  - rd_burst_num_o := 0.
  - rd_start_addr_o := the current channel's address register; rd_ch_o := channel pointer.
  - If abort_i, go to ABORT.
  - Else if rd_req_o & arbitor_ack_i, rd_burst_num_o := latched burst count and go to RD_PROC.
  - An ack without a request is ignored.
- RD_PROC:
  - rd_ddr_en_o = ~rd_ddr_done_i (combinational).
  - abort_i is deferred until rd_ddr_done_i.
  - On rd_ddr_done_i:
    - Current channel address += stride, modulo 2^ADDR_WIDTH (wrap silently).
    - Channel pointer advances; when it wraps from NUM_CH-1 to 0, req_cnt_o increments.
    - Next state:
      - ABORT if abort_i.
      - DONE if the wrap made req_cnt_o equal the latched request count.
      - REQ_WAIT otherwise.
- DONE: done_o = 1 for exactly one cycle; busy_o := 0; go to IDLE.
- ABORT: aborted_o = 1 for exactly one cycle; busy_o := 0; go to IDLE. done_o is not asserted.
- Request order for channels A and B: A0, B0, A1, B1, ...
  - Request k of channel c reads from base[c] + k*stride.
- Latency:
  - The first rd_req_o is asserted 1 cycle after start_i (given ip_ready_i high).
  - rd_ddr_en_o rises on the cycle after ack.
- Simultaneous start_i and abort_i in IDLE: start is taken, then abort is handled in REQ_WAIT. The result is one aborted_o pulse with no reads.
- start_i outside IDLE is ignored; cfg_* changes during a job have no effect.
- Reset asserted mid-job returns to reset values immediately. No done_o or aborted_o pulse is produced.

Test Plan:
- NUM_CH=2, base0=0x1000, base1=0x8000, stride=0x90, burst=17, req=3; ip_ready_i and ack always high → addresses 0x1000, 0x8000, 0x1090, 0x8090, 0x1120, 0x8120.
  - rd_ch_o sequence 0,1,0,1,0,1; rd_burst_num_o = 17 in each RD_PROC.
  - One done_o pulse; req_cnt_o = 3.
- cfg_req_num_i = 0 → no rd_req_o; done_o pulses 2 cycles after start_i; busy_o high for 1 cycle.
- Hold ip_ready_i low for 10 cycles in REQ_WAIT → rd_req_o stays low and the FSM stays in REQ_WAIT; after release, the request resumes at the same address.
- Assert abort_i mid RD_PROC of request 2 → rd_ddr_en_o stays high until rd_ddr_done_i.
  - Then aborted_o pulses once; no done_o pulse; no further rd_req_o.
- Drop init_calib_complete_i for 5 cycles during REQ_WAIT with ack high → no transition and rd_req_o = 0; the FSM proceeds once calibration returns.
- base0 = 0x3FFFFFF0, stride = 0x20, NUM_CH=1, req=2 → addresses 0x3FFFFFF0, then 0x00000010 (wrap).
  - Also pulse rstn_i low mid-job → all outputs return to 0 asynchronously.
